// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
    localparam int LAT_W     = 4;
    localparam int DMEM_WORD = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the CPU datapath and the data memory.
// Byte enables exist only when DMEM_BYTE_WRITE_EN is defined.
interface dmem_responder_if;
    logic                           req;
    logic                           we;
    logic [31:0]                    addr;
    logic [dmem_pkg::DMEM_WORD-1:0] wdata;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]                     be;
`endif
    logic                           ready;
    logic [dmem_pkg::DMEM_WORD-1:0] rdata;
    logic                           err;
    logic                           busy;

    modport master (
`ifdef DMEM_BYTE_WRITE_EN
        output be,
`endif
        output req, we, addr, wdata,
        input  ready, rdata, err, busy
    );

    modport slave (
`ifdef DMEM_BYTE_WRITE_EN
        input  be,
`endif
        input  req, we, addr, wdata,
        output ready, rdata, err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word storage with per-byte write enables.
// Contents are never reset; rdata updates only on reads.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DMEM_WORD-1:0]  wdata,
    input  logic [3:0]            be,
    output logic [DMEM_WORD-1:0]  rdata
);
    logic [DMEM_WORD-1:0] mem_q [2**ADDR_WIDTH];
    logic [DMEM_WORD-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait cycles, then a one-cycle response.
// Optional DMEM_BYTE_WRITE_EN adds byte-enabled stores.
//
//  state | meaning
//  IDLE  | waiting for req; the accept edge captures the request
//  WAIT  | latency countdown, cnt reaches 0 before the response edge
//  RESP  | ready/err/rdata presented for one cycle; req ignored
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam bit              ZERO_LAT = (LATENCY == 0);
    localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    state_e                  state_q, state_d;
    logic [LAT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, mis_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [DMEM_WORD-1:0]    wdata_q;
    logic [3:0]              be_q;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    rd_sel_q, rd_sel_d;

    logic                    accept, enter_resp;
    logic [3:0]              be_in;
    logic                    acc_we, acc_mis;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [DMEM_WORD-1:0]    acc_wdata;
    logic [3:0]              acc_be;
    logic                    mem_en;
    logic [DMEM_WORD-1:0]    mem_rdata;
    logic                    unused_addr;

`ifdef DMEM_BYTE_WRITE_EN
    assign be_in = bus.be;
`else
    assign be_in = 4'hF;
`endif

    // Upper address bits alias onto the array by design.
    assign unused_addr = ^bus.addr[31:ADDR_WIDTH+2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (ZERO_LAT) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // With zero latency the access happens on the accept edge itself.
        acc_we    = ZERO_LAT ? bus.we                       : we_q;
        acc_mis   = ZERO_LAT ? (bus.addr[1:0] != 2'b00)     : mis_q;
        acc_idx   = ZERO_LAT ? bus.addr[ADDR_WIDTH+1:2]     : idx_q;
        acc_wdata = ZERO_LAT ? bus.wdata                    : wdata_q;
        acc_be    = ZERO_LAT ? be_in                        : be_q;

        mem_en   = enter_resp & ~acc_mis;
        ready_d  = enter_resp;
        err_d    = enter_resp & acc_mis;
        rd_sel_d = enter_resp & ~acc_mis & ~acc_we;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= bus.we;
            mis_q   <= (bus.addr[1:0] != 2'b00);
            idx_q   <= bus.addr[ADDR_WIDTH+1:2];
            wdata_q <= bus.wdata;
            be_q    <= be_in;
        end
    end

    dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (acc_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (mem_rdata)
    );

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rd_sel_q ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances share one stimulus stream
// and are checked cycle by cycle against a timestamp-based transaction model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    dmem_responder_if bus_a();
    dmem_responder_if bus_b();

    assign bus_a.req = req;  assign bus_a.we = we;  assign bus_a.addr = addr;  assign bus_a.wdata = wdata;
    assign bus_b.req = req;  assign bus_b.we = we;  assign bus_b.addr = addr;  assign bus_b.wdata = wdata;
`ifdef DMEM_BYTE_WRITE_EN
    assign bus_a.be = be;
    assign bus_b.be = be;
`endif

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    logic        o_ready [2];
    logic        o_err   [2];
    logic        o_busy  [2];
    logic [31:0] o_rdata [2];
    assign o_ready[0] = bus_a.ready;  assign o_ready[1] = bus_b.ready;
    assign o_err[0]   = bus_a.err;    assign o_err[1]   = bus_b.err;
    assign o_busy[0]  = bus_a.busy;   assign o_busy[1]  = bus_b.busy;
    assign o_rdata[0] = bus_a.rdata;  assign o_rdata[1] = bus_b.rdata;

    // Reference model: one outstanding request per instance, tracked by edge timestamps.
    int          edge_n;
    bit          pend   [2];
    int          resp_e [2];
    int          free_e [2];
    bit          p_we   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_be   [2];
    logic [31:0] mem_m  [2][1024];
    bit          e_ready[2];
    bit          e_err  [2];
    bit          e_busy [2];
    logic [31:0] e_rdata[2];

    int          ready_cnt [2];
    logic [31:0] last_rdata[2];
    logic        last_err  [2];
    int          n_checks;
    int          n_pass;

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pend[d] = 1'b0;  free_e[d] = 0;
            e_ready[d] = 1'b0;  e_err[d] = 1'b0;  e_busy[d] = 1'b0;  e_rdata[d] = '0;
        end
    endtask

    task automatic model_edge();
        int idx;
        for (int d = 0; d < 2; d++) begin
            e_ready[d] = 1'b0;  e_err[d] = 1'b0;  e_rdata[d] = '0;
            if (!pend[d] && edge_n >= free_e[d] && req) begin
                pend[d]    = 1'b1;
                p_we[d]    = we;
                p_addr[d]  = addr;
                p_wdata[d] = wdata;
`ifdef DMEM_BYTE_WRITE_EN
                p_be[d]    = be;
`else
                p_be[d]    = 4'hF;
`endif
                resp_e[d]  = edge_n + lat_of(d);
                free_e[d]  = edge_n + lat_of(d) + 2;
            end
            if (pend[d] && edge_n == resp_e[d]) begin
                pend[d]    = 1'b0;
                e_ready[d] = 1'b1;
                if (p_addr[d] % 4 != 0) begin
                    e_err[d] = 1'b1;
                end else begin
                    idx = int'((p_addr[d] / 4) % 1024);
                    if (p_we[d]) begin
                        for (int i = 0; i < 4; i++)
                            if (p_be[d][i]) mem_m[d][idx][8*i +: 8] = p_wdata[d][8*i +: 8];
                    end else begin
                        e_rdata[d] = mem_m[d][idx];
                    end
                end
            end
            e_busy[d] = pend[d] || e_ready[d];
        end
        edge_n++;
    endtask

    task automatic compare();
        string nm;
        for (int d = 0; d < 2; d++) begin
            nm = $sformatf("L%0d", lat_of(d));
            check({nm, " ready"}, 32'(o_ready[d]), 32'(e_ready[d]));
            check({nm, " busy"},  32'(o_busy[d]),  32'(e_busy[d]));
            if (e_ready[d]) begin
                check({nm, " err"},   32'(o_err[d]), 32'(e_err[d]));
                check({nm, " rdata"}, o_rdata[d],    e_rdata[d]);
            end
            if (o_ready[d] === 1'b1) begin
                ready_cnt[d]++;
                last_rdata[d] = o_rdata[d];
                last_err[d]   = o_err[d];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        else        edge_n++;
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] dt, input logic [3:0] b);
        req = r;  we = w;  addr = a;  wdata = dt;  be = b;
        tick();
    endtask

    // One request followed by idle cycles with junk on the request fields.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] dt, input logic [3:0] b);
        drive(1'b1, w, a, dt, b);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            check("rst ready", 32'(o_ready[d]), 32'd0);
            check("rst err",   32'(o_err[d]),   32'd0);
            check("rst busy",  32'(o_busy[d]),  32'd0);
            check("rst rdata", o_rdata[d],      32'd0);
        end
    endtask

    // Asserted mid-cycle so outputs are checked before the next clock edge.
    task automatic reset_mid();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int          cnt0, cnt1;
        logic [31:0] a;
        edge_n = 0;  n_checks = 0;  n_pass = 0;
        ready_cnt[0] = 0;  ready_cnt[1] = 0;
        model_reset();

        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF);

        // Store then load back through both instances.
        cnt0 = ready_cnt[0];
        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        check("store ready", 32'(ready_cnt[0] - cnt0), 32'd1);
        check("store err",   32'(last_err[0]), 32'd0);
        check("store rdata", last_rdata[0],    32'd0);
        xact(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        check("load 0x10", last_rdata[0], 32'hDEAD_BEEF);
        check("load 0x10 L0", last_rdata[1], 32'hDEAD_BEEF);

        // Misaligned load, then the word is still intact.
        xact(1'b0, 32'h0000_0013, 32'h0, 4'h0);
        check("misal err",   32'(last_err[0]), 32'd1);
        check("misal rdata", last_rdata[0],    32'd0);
        xact(1'b0, 32'hFFFF_F010, 32'h0, 4'h0);
        check("alias load", last_rdata[0], 32'hDEAD_BEEF);

        // req held high with incrementing addresses.
        cnt0 = ready_cnt[0];  cnt1 = ready_cnt[1];
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 4; i++)  drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("back2back L2", 32'(ready_cnt[0] - cnt0), 32'd5);
        check("back2back L0", 32'(ready_cnt[1] - cnt1), 32'd10);

        // Reset during WAIT aborts the store.
        cnt0 = ready_cnt[0];
        drive(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
        req = 1'b0;
        reset_mid();
        check("abort no ready", 32'(ready_cnt[0] - cnt0), 32'd0);
        xact(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        check("abort load", last_rdata[0], 32'hDEAD_BEEF);

`ifdef DMEM_BYTE_WRITE_EN
        xact(1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010);
        xact(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        check("byte store", last_rdata[0], 32'hDEAD_AAEF);
        cnt0 = ready_cnt[0];
        xact(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
        check("be0 ready", 32'(ready_cnt[0] - cnt0), 32'd1);
        xact(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        check("be0 load", last_rdata[0], 32'hDEAD_AAEF);
`else
        xact(1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010);
        xact(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        check("word store", last_rdata[0], 32'h0000_AA00);
`endif

        // Randomized traffic over a small initialized window with aliasing and misalignment.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 149) == 0) begin
                drive(1'b1, 1'($urandom), a, $urandom, 4'($urandom));
                req = 1'b0;
                reset_mid();
            end else begin
                drive(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
